// File: rtl/video_timing_gen.sv
// video_timing_gen: 12-bit h/v raster counters producing registered active-low
// syncs, data enable, a per-frame latched test pattern and pixel coordinates.
// Ports: clock, reset_n (async, active low); pattern_sel, fill_color in;
//        vsync, hsync, de, pixel, pos_x, pos_y, frame_top out (all registered).
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] fill_color,
  output logic        vsync,
  output logic        hsync,
  output logic        de,
  output logic [23:0] pixel,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        frame_top
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HL  = 12'(H_TOTAL - 1);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VL  = 12'(V_TOTAL - 1);
  localparam logic [11:0] BL  = 12'(BAR_W - 1);

  logic [11:0] hc_q, hc_d;
  logic [11:0] vc_q, vc_d;
  logic [11:0] bpx_q, bpx_d;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] fill_q, fill_d;
  logic        h_end, v_end;

  logic        act_h, act_v, act;
  logic        vs_d, hs_d, de_d, ft_d;
  logic [23:0] pix_d;
  logic [11:0] px_d, py_d;

  logic        vs_q, hs_q, de_q, ft_q;
  logic [23:0] pix_q;
  logic [11:0] px_q, py_q;

  function automatic logic [23:0] bar_rgb(input logic [2:0] i);
    logic [23:0] c;
    c = 24'h000000;
    unique case (i)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      3'd7: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Raster counters, bar sub-counter and frame-boundary pattern latch
  always_comb begin
    h_end  = (hc_q == HL);
    v_end  = (vc_q == VL);
    hc_d   = h_end ? 12'd0 : hc_q + 12'd1;
    vc_d   = vc_q;
    bpx_d  = bpx_q + 12'd1;
    bar_d  = bar_q;
    pat_d  = pat_q;
    fill_d = fill_q;
    if (h_end) begin
      vc_d = v_end ? 12'd0 : vc_q + 12'd1;
    end
    // Bar index tracks hc without a divider; saturates at 7
    // so a ragged tail past 8*BAR_W stays in the last bar.
    if (h_end) begin
      bpx_d = 12'd0;
      bar_d = 3'd0;
    end else if (bpx_q == BL) begin
      bpx_d = 12'd0;
      if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
    end
    if (h_end && v_end) begin
      pat_d  = pattern_sel;
      fill_d = fill_color;
    end
  end

  // Output decode from the current counter state
  always_comb begin
    act_h = (hc_q < HA);
    act_v = (vc_q < VA);
    act   = act_h && act_v;
    hs_d  = !((hc_q >= HS0) && (hc_q < HS1));
    vs_d  = !((vc_q >= VS0) && (vc_q < VS1));
    de_d  = act;
    px_d  = act ? hc_q : 12'd0;
    py_d  = act_v ? vc_q : 12'd0;
    ft_d  = (hc_q == 12'd0) && (vc_q == 12'd0);
    pix_d = 24'h000000;
    if (act) begin
      unique case (pat_q)
        2'd0: pix_d = bar_rgb(bar_q);
        2'd1: pix_d = fill_q;
        2'd2: pix_d = {3{hc_q[7:0]}};
        2'd3: pix_d = ((hc_q[4:0] == 5'd0) || (vc_q[4:0] == 5'd0))
                      ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hc_q   <= '0;
      vc_q   <= '0;
      bpx_q  <= '0;
      bar_q  <= '0;
      pat_q  <= '0;
      fill_q <= '0;
      vs_q   <= 1'b1;
      hs_q   <= 1'b1;
      de_q   <= 1'b0;
      ft_q   <= 1'b0;
      pix_q  <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      bpx_q  <= bpx_d;
      bar_q  <= bar_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      vs_q   <= vs_d;
      hs_q   <= hs_d;
      de_q   <= de_d;
      ft_q   <= ft_d;
      pix_q  <= pix_d;
      px_q   <= px_d;
      py_q   <= py_d;
    end
  end

  assign vsync     = vs_q;
  assign hsync     = hs_q;
  assign de        = de_q;
  assign frame_top = ft_q;
  assign pixel     = pix_q;
  assign pos_x     = px_q;
  assign pos_y     = py_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed expectations queued by cycle number,
// popped and compared by an independent monitor on the falling edge.
module tb_video_timing_gen;

  // Full horizontal timing; vertical shortened to keep four frames short.
  // V: 20 active, 2 fp, 2 sync, 2 bp -> 26 lines, vsync on lines 22..23.
  localparam int HT = 800;
  localparam int VT = 26;
  localparam int FR = HT * VT;

  typedef enum int {F_VS, F_HS, F_DE, F_PIX, F_PX, F_PY, F_FT} fld_e;
  typedef struct {
    int          cyc;
    fld_e        f;
    logic [23:0] v;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  psel = 2'd0;
  logic [23:0] fill = 24'h0;
  logic        vsync, hsync, de, frame_top;
  logic [23:0] pixel;
  logic [11:0] pos_x, pos_y;

  exp_t q[$];
  int   cyc = -1;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .pattern_sel(psel),
    .fill_color(fill),
    .vsync(vsync),
    .hsync(hsync),
    .de(de),
    .pixel(pixel),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .frame_top(frame_top)
  );

  // Cycle 0 is the first rising edge after reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= -1;
    else cyc <= cyc + 1;

  function automatic logic [23:0] got(input fld_e f);
    logic [23:0] r;
    r = '0;
    case (f)
      F_VS:  r = {23'd0, vsync};
      F_HS:  r = {23'd0, hsync};
      F_DE:  r = {23'd0, de};
      F_PIX: r = pixel;
      F_PX:  r = {12'd0, pos_x};
      F_PY:  r = {12'd0, pos_y};
      F_FT:  r = {23'd0, frame_top};
      default: r = 'x;
    endcase
    return r;
  endfunction

  task automatic ex(input int c, input fld_e f,
                    input logic [23:0] v, input string nm);
    exp_t e;
    e.cyc = c;
    e.f   = f;
    e.v   = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_run++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: slot %0d skipped (now cycle %0d)",
                 e.nm, e.cyc, cyc);
      end else if (got(e.f) !== e.v) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h, expected %h",
                 e.nm, cyc, got(e.f), e.v);
      end
    end
  end

  task automatic push_reset_vals();
    ex(-1, F_VS,  24'd1, "rst_vsync");
    ex(-1, F_HS,  24'd1, "rst_hsync");
    ex(-1, F_DE,  24'd0, "rst_de");
    ex(-1, F_PIX, 24'd0, "rst_pixel");
    ex(-1, F_PX,  24'd0, "rst_pos_x");
    ex(-1, F_PY,  24'd0, "rst_pos_y");
    ex(-1, F_FT,  24'd0, "rst_frame_top");
  endtask

  initial begin
    push_reset_vals();
    // first pixel of frame 0, colour bars
    ex(0, F_DE,  24'd1, "first_de");
    ex(0, F_FT,  24'd1, "first_frame_top");
    ex(0, F_PX,  24'd0, "first_pos_x");
    ex(0, F_PY,  24'd0, "first_pos_y");
    ex(0, F_PIX, 24'hFFFFFF, "first_pixel");
    ex(0, F_VS,  24'd1, "first_vsync");
    ex(0, F_HS,  24'd1, "first_hsync");
    ex(1, F_FT,  24'd0, "ft_one_clock");
    ex(1, F_PX,  24'd1, "pos_x_1");
    ex(79,  F_PIX, 24'hFFFFFF, "bar_x79");
    ex(80,  F_PIX, 24'hFFFF00, "bar_x80");
    ex(80,  F_PX,  24'd80, "pos_x_80");
    ex(400, F_PIX, 24'hFF0000, "bar_x400");
    ex(639, F_DE,  24'd1, "de_last");
    ex(639, F_PIX, 24'h000000, "bar_x639");
    ex(639, F_PX,  24'd639, "pos_x_639");
    ex(640, F_DE,  24'd0, "de_fall");
    ex(640, F_PIX, 24'h000000, "pix_blank");
    ex(640, F_PX,  24'd0, "pos_x_blank");
    ex(655, F_HS,  24'd1, "hs_before");
    ex(656, F_HS,  24'd0, "hs_fall");
    ex(751, F_HS,  24'd0, "hs_last_low");
    ex(752, F_HS,  24'd1, "hs_rise");
    ex(799, F_DE,  24'd0, "de_line_end");
    ex(800, F_DE,  24'd1, "de_line1");
    ex(800, F_PY,  24'd1, "pos_y_1");
    ex(800, F_FT,  24'd0, "ft_line1");
    ex(800, F_PIX, 24'hFFFFFF, "bar_line1");
    // pattern change at line 10 must not show in this frame
    ex(12*HT + 80, F_PIX, 24'hFFFF00, "latch_hold");
    ex(19*HT, F_DE, 24'd1, "de_line19");
    ex(19*HT, F_PY, 24'd19, "pos_y_19");
    ex(20*HT - 1, F_DE, 24'd0, "de_l19_end");
    ex(20*HT, F_DE, 24'd0, "de_line20");
    ex(20*HT, F_PY, 24'd0, "pos_y_line20");
    ex(20*HT + 5, F_DE, 24'd0, "de_vblank");
    ex(22*HT - 1, F_VS, 24'd1, "vs_before");
    ex(22*HT, F_VS, 24'd0, "vs_fall");
    ex(24*HT - 1, F_VS, 24'd0, "vs_last_low");
    ex(24*HT, F_VS, 24'd1, "vs_rise");
    ex(FR - 1, F_FT, 24'd0, "ft_frame_end");
    ex(FR - 1, F_DE, 24'd0, "de_frame_end");
    // frame 1: solid fill latched at end of frame 0
    ex(FR, F_FT,  24'd1, "ft_frame1");
    ex(FR, F_DE,  24'd1, "de_frame1");
    ex(FR, F_PIX, 24'h123456, "solid_first");
    ex(FR + 5*HT + 100, F_PIX, 24'h123456, "solid_hold");
    // frame 2: grey ramp
    ex(2*FR, F_FT,  24'd1, "ft_frame2");
    ex(2*FR, F_PIX, 24'h000000, "ramp_x0");
    ex(2*FR + 255, F_PIX, 24'hFFFFFF, "ramp_x255");
    ex(2*FR + 256, F_PIX, 24'h000000, "ramp_wrap");
    ex(2*FR + 300, F_PIX, 24'h2C2C2C, "ramp_x300");
    // frame 3: grid
    ex(3*FR, F_FT, 24'd1, "ft_frame3");
    ex(3*FR + 5, F_PIX, 24'hFFFFFF, "grid_5_0");
    ex(3*FR + 5*HT + 32, F_PIX, 24'hFFFFFF, "grid_32_5");
    ex(3*FR + 5*HT + 33, F_PIX, 24'h000000, "grid_33_5");
    ex(3*FR + 17*HT + 33, F_PIX, 24'h000000, "grid_33_17");

    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(10*HT);
    psel = 2'd1;
    fill = 24'h123456;
    wait_cyc(FR + 1200);
    psel = 2'd2;
    fill = 24'hABCDEF;
    wait_cyc(2*FR + 400);
    psel = 2'd3;

    // asynchronous reset in the middle of an active line
    wait_cyc(3*FR + 17*HT + 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push_reset_vals();
    repeat (3) @(negedge clk);
    ex(0, F_DE,  24'd1, "rerelease_de");
    ex(0, F_FT,  24'd1, "rerelease_ft");
    ex(0, F_PIX, 24'hFFFFFF, "rerelease_bars");
    rst_n = 1'b1;
    wait_cyc(3);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL %s: slot %0d never reached", e.nm, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
